// File: rtl/target_scheduler_if.sv
// Player-facing signal bundle for the target scheduler: round control,
// 1 Hz tick and buttons in, target lamps, score pulse and round timer out.
interface target_scheduler_if;
  logic       startGame;
  logic       sec_tick;
  logic [3:0] btn;
  logic [3:0] target_led;
  logic       player_scored;
  logic       timer_expired;
  logic [5:0] time_left;

  // Drives the game inputs and observes the scheduler outputs.
  modport master (
    output startGame,
    output sec_tick,
    output btn,
    input  target_led,
    input  player_scored,
    input  timer_expired,
    input  time_left
  );

  // The scheduler itself.
  modport slave (
    input  startGame,
    input  sec_tick,
    input  btn,
    output target_led,
    output player_scored,
    output timer_expired,
    output time_left
  );
endinterface

// File: rtl/target_scheduler.sv
// Whack-a-target round scheduler: lights one of four targets at a time,
// separated by dark gaps, scores clean hits and runs the round timer.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | out of reset, waiting for startGame
// GAP   | all targets dark for GAP_CYCLES cycles
// LIT   | one target lit until hit, miss or WINDOW_CYCLES timeout
// DONE  | round over, timer_expired high, waiting for startGame
module target_scheduler #(
  parameter int GAME_TIME     = 30,
  parameter int WINDOW_CYCLES = 100_000_000,
  parameter int GAP_CYCLES    = 25_000_000
) (
  input  logic              clkIn,
  input  logic              reset,
  target_scheduler_if.slave bus
);

  localparam int MAX_CYCLES = (WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] GAP_TC    = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] WIN_TC    = CW'(WINDOW_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [5:0]    TIME_INIT = 6'(GAME_TIME);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    LIT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q;
  state_t        state_nxt;
  logic [CW-1:0] cnt_q;
  logic [5:0]    time_left_q;
  logic [1:0]    tgt_q;
  logic [7:0]    lfsr_q;
  logic [3:0]    btn_prev_q;
  logic          scored_q;

  logic [3:0]    rise;
  logic [3:0]    tgt_onehot;
  logic          hit;
  logic          miss;
  logic          final_tick;
  logic          gap_done;
  logic          win_done;
  logic          lfsr_fb;
  logic [1:0]    new_tgt;
  logic [3:0]    led_c;
  logic          expired_c;

  // Event decode shared by the FSM and the datapath.
  assign rise       = bus.btn & ~btn_prev_q;
  assign tgt_onehot = 4'b0001 << tgt_q;
  assign miss       = |(rise & ~tgt_onehot);
  assign hit        = (|(rise & tgt_onehot)) && !miss;
  assign final_tick = bus.sec_tick && (time_left_q == 6'd1);
  assign gap_done   = (cnt_q == GAP_TC);
  assign win_done   = (cnt_q == WIN_TC);
  assign lfsr_fb    = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  // Never light the same target twice in a row: bump to the neighbour.
  assign new_tgt    = (lfsr_q[1:0] == tgt_q) ? (lfsr_q[1:0] + 2'd1) : lfsr_q[1:0];

  // State register.
  always_ff @(posedge clkIn) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Next-state logic; the final second tick overrides every play transition.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      IDLE: if (bus.startGame) state_nxt = GAP;
      GAP: begin
        if (final_tick)    state_nxt = DONE;
        else if (gap_done) state_nxt = LIT;
      end
      LIT: begin
        if (final_tick)                    state_nxt = DONE;
        else if (hit || miss || win_done)  state_nxt = GAP;
      end
      DONE: if (bus.startGame) state_nxt = GAP;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    led_c     = 4'b0000;
    expired_c = 1'b0;
    unique case (state_q)
      LIT:     led_c     = tgt_onehot;
      DONE:    expired_c = 1'b1;
      default: begin
        led_c     = 4'b0000;
        expired_c = 1'b0;
      end
    endcase
  end

  // Datapath: phase counter, round timer, target pick, LFSR, button history, score pulse.
  always_ff @(posedge clkIn) begin
    if (!reset) begin
      cnt_q       <= '0;
      time_left_q <= TIME_INIT;
      tgt_q       <= 2'd0;
      lfsr_q      <= 8'hA5;
      btn_prev_q  <= 4'hF;
      scored_q    <= 1'b0;
    end else begin
      lfsr_q     <= {lfsr_q[6:0], lfsr_fb};
      btn_prev_q <= bus.btn;
      // A hit still pulses even when the final tick ends the round that edge.
      scored_q   <= (state_q == LIT) && hit;

      if (state_nxt != state_q)
        cnt_q <= '0;
      else if (state_q == GAP || state_q == LIT)
        cnt_q <= cnt_q + CNT_ONE;
      else
        cnt_q <= '0;

      if ((state_q == IDLE || state_q == DONE) && bus.startGame)
        time_left_q <= TIME_INIT;
      else if ((state_q == GAP || state_q == LIT) && bus.sec_tick && time_left_q != 6'd0)
        time_left_q <= time_left_q - 6'd1;

      if (state_q == GAP && state_nxt == LIT)
        tgt_q <= new_tgt;
    end
  end

  assign bus.target_led    = led_c;
  assign bus.timer_expired = expired_c;
  assign bus.player_scored = scored_q;
  assign bus.time_left     = time_left_q;

endmodule

// File: tb/tb_target_scheduler.sv
// Directed bench for target_scheduler with short timing parameters.
module tb_target_scheduler;
  localparam int GT = 3;
  localparam int WC = 8;
  localparam int GC = 4;

  logic clkIn = 1'b0;
  logic reset = 1'b0;

  target_scheduler_if bus();

  target_scheduler #(
    .GAME_TIME    (GT),
    .WINDOW_CYCLES(WC),
    .GAP_CYCLES   (GC)
  ) dut (
    .clkIn(clkIn),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clkIn = ~clkIn;

  int n_checks  = 0;
  int n_fail    = 0;
  int score_cnt = 0;

  // Reference LFSR; m_lfsr_d holds the value the design used at the last edge.
  logic [7:0] m_lfsr;
  logic [7:0] m_lfsr_d;
  logic [1:0] m_prev;

  // Reference LFSR stepping alongside the design.
  always @(posedge clkIn) begin
    if (!reset) m_lfsr <= 8'hA5;
    else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    m_lfsr_d <= m_lfsr;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample outputs on the falling edge.
  task automatic step();
    @(negedge clkIn);
    if (bus.player_scored) score_cnt++;
  endtask

  task automatic wait_lit(output int gap);
    gap = 0;
    while (bus.target_led == 4'b0000 && gap < 20) begin
      gap++;
      step();
    end
  endtask

  task automatic check_target(input string tag);
    logic [1:0] e;
    e = m_lfsr_d[1:0];
    if (e == m_prev) e = e + 2'd1;
    check_eq(tag, 32'(bus.target_led), 32'(4'b0001 << e));
    m_prev = e;
  endtask

  // Stimulus and checks.
  initial begin
    int g;
    int s0;
    int lit_cnt;
    logic [3:0] led;
    logic [3:0] prev_led;

    bus.startGame = 1'b0;
    bus.sec_tick  = 1'b0;
    bus.btn       = 4'b0000;
    reset         = 1'b0;
    m_prev        = 2'd0;
    step();
    step();
    check_eq("rst_led",     32'(bus.target_led), 0);
    check_eq("rst_scored",  32'(bus.player_scored), 0);
    check_eq("rst_expired", 32'(bus.timer_expired), 0);
    check_eq("rst_time",    32'(bus.time_left), GT);

    reset = 1'b1;
    step();
    step();
    check_eq("idle_led",  32'(bus.target_led), 0);
    check_eq("idle_time", 32'(bus.time_left), GT);

    // Start a round: four dark cycles then a lit target.
    bus.startGame = 1'b1;
    step();
    bus.startGame = 1'b0;
    wait_lit(g);
    check_eq("gap_len1", g, GC);
    check_target("tgt1");
    check_eq("time_start", 32'(bus.time_left), GT);

    // Correct press two cycles into LIT.
    step();
    s0 = score_cnt;
    bus.btn = bus.target_led;
    step();
    check_eq("hit_pulse", score_cnt, s0 + 1);
    check_eq("hit_led_off", 32'(bus.target_led), 0);
    bus.btn = 4'b0000;
    wait_lit(g);
    check_eq("gap_len2", g, GC);
    check_eq("hit_once", score_cnt, s0 + 1);
    check_target("tgt2");

    // Wrong button alone.
    s0  = score_cnt;
    led = bus.target_led;
    bus.btn = {led[2:0], led[3]};
    step();
    check_eq("miss_led_off", 32'(bus.target_led), 0);
    check_eq("miss_score", score_cnt, s0);
    bus.btn = 4'b0000;
    wait_lit(g);
    check_eq("gap_len3", g, GC);
    check_target("tgt3");

    // Correct and wrong together.
    led = bus.target_led;
    bus.btn = led | {led[2:0], led[3]};
    step();
    check_eq("both_led_off", 32'(bus.target_led), 0);
    check_eq("both_score", score_cnt, s0);
    bus.btn = 4'b0000;
    wait_lit(g);
    check_target("tgt4");

    // No press: window timeout.
    lit_cnt = 0;
    while (bus.target_led != 4'b0000 && lit_cnt < 20) begin
      lit_cnt++;
      step();
    end
    check_eq("window_len", lit_cnt, WC);
    check_eq("timeout_score", score_cnt, s0);

    // Buttons held from GAP into LIT must not score.
    bus.btn = 4'hF;
    wait_lit(g);
    check_eq("gap_len_held", g, GC);
    check_target("tgt5");
    led = bus.target_led;
    step();
    step();
    step();
    check_eq("held_led", 32'(bus.target_led), 32'(led));
    check_eq("held_score", score_cnt, s0);
    bus.btn = 4'b0000;
    step();
    bus.btn = led;
    step();
    check_eq("held_then_hit", score_cnt, s0 + 1);
    bus.btn = 4'b0000;

    // Round timer runs out.
    wait_lit(g);
    check_target("tgt6");
    bus.sec_tick = 1'b1; step(); bus.sec_tick = 1'b0;
    check_eq("tick1_time", 32'(bus.time_left), 2);
    check_eq("tick1_exp", 32'(bus.timer_expired), 0);
    bus.sec_tick = 1'b1; step(); bus.sec_tick = 1'b0;
    check_eq("tick2_time", 32'(bus.time_left), 1);
    bus.sec_tick = 1'b1; step(); bus.sec_tick = 1'b0;
    check_eq("tick3_time", 32'(bus.time_left), 0);
    check_eq("tick3_exp", 32'(bus.timer_expired), 1);
    check_eq("tick3_led", 32'(bus.target_led), 0);
    s0 = score_cnt;
    bus.sec_tick = 1'b1; bus.btn = 4'hF; step();
    bus.sec_tick = 1'b0; bus.btn = 4'b0000; step();
    bus.btn = 4'hF; bus.sec_tick = 1'b1; step();
    bus.btn = 4'b0000; bus.sec_tick = 1'b0; step();
    check_eq("done_time", 32'(bus.time_left), 0);
    check_eq("done_exp", 32'(bus.timer_expired), 1);
    check_eq("done_led", 32'(bus.target_led), 0);
    check_eq("done_score", score_cnt, s0);

    // Restart, then hit on the final tick.
    bus.startGame = 1'b1; step(); bus.startGame = 1'b0;
    check_eq("restart_time", 32'(bus.time_left), GT);
    check_eq("restart_exp", 32'(bus.timer_expired), 0);
    wait_lit(g);
    check_target("tgt7");
    bus.sec_tick = 1'b1; step(); bus.sec_tick = 1'b0;
    bus.sec_tick = 1'b1; step(); bus.sec_tick = 1'b0;
    check_eq("pre_final_time", 32'(bus.time_left), 1);
    s0  = score_cnt;
    led = bus.target_led;
    bus.btn = led;
    bus.sec_tick = 1'b1;
    step();
    bus.btn = 4'b0000;
    bus.sec_tick = 1'b0;
    check_eq("final_score", score_cnt, s0 + 1);
    check_eq("final_time", 32'(bus.time_left), 0);
    check_eq("final_exp", 32'(bus.timer_expired), 1);
    check_eq("final_led", 32'(bus.target_led), 0);
    step();
    step();
    check_eq("final_once", score_cnt, s0 + 1);
    bus.startGame = 1'b1; step(); bus.startGame = 1'b0;
    check_eq("restart2_time", 32'(bus.time_left), GT);
    check_eq("restart2_exp", 32'(bus.timer_expired), 0);

    // Reset mid-round with a correct press on the same edge; buttons held through reset.
    wait_lit(g);
    check_target("tgt8");
    s0 = score_cnt;
    bus.btn = 4'hF;
    reset = 1'b0;
    m_prev = 2'd0;
    step();
    check_eq("rst_mid_score", score_cnt, s0);
    check_eq("rst_mid_led", 32'(bus.target_led), 0);
    check_eq("rst_mid_time", 32'(bus.time_left), GT);
    check_eq("rst_mid_exp", 32'(bus.timer_expired), 0);
    step();
    reset = 1'b1;
    step();
    step();
    check_eq("post_rst_idle", 32'(bus.target_led), 0);
    bus.startGame = 1'b1; step(); bus.startGame = 1'b0;
    wait_lit(g);
    check_eq("gap_len_rst", g, GC);
    check_target("tgt9");
    step();
    step();
    step();
    check_eq("held_rst_score", score_cnt, s0);
    bus.btn = 4'b0000;
    step();

    // 200 consecutive targets, each hit immediately.
    for (int i = 0; i < 200; i++) begin
      prev_led = bus.target_led;
      bus.btn = prev_led;
      step();
      bus.btn = 4'b0000;
      wait_lit(g);
      check_target("tgt_seq");
      check_eq("no_repeat", 32'(bus.target_led == prev_led), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
